// File: rtl/decoder_24_pipe.sv
// Registered 2-to-4 decoder behind a 2-entry skid FIFO with valid/ready on both sides.
// Define DECODER_CNT_EN to add per-line saturating hit counters (cnt_clr / hit_cnt ports).
module decoder_24_pipe
`ifdef DECODER_CNT_EN
#(
    parameter int COUNT_W = 8
)
`endif
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [1:0]             in_code,
    input  logic                   in_en,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [3:0]             out_y
`ifdef DECODER_CNT_EN
    ,
    input  logic                   cnt_clr,
    output logic [4*COUNT_W-1:0]   hit_cnt
`endif
);

    logic [3:0] mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    logic       push;
    logic       pop;
    logic [3:0] word;

    // The word, not the code, is stored so the output side is a plain register read.
    assign word      = in_en ? (4'b0001 << in_code) : 4'b0000;
    assign in_ready  = !rst && (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_y     = out_valid ? mem_q[rd_ptr_q] : 4'b0000;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only observed while count_q says they are live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= word;
        end
    end

`ifdef DECODER_CNT_EN
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt
        logic [COUNT_W-1:0] cnt_q, cnt_d;

        // Clear beats increment; counters stick at all-ones instead of wrapping.
        always_comb begin
            cnt_d = cnt_q;
            if (cnt_clr) begin
                cnt_d = '0;
            end else if (pop && out_y[gi] && (cnt_q != {COUNT_W{1'b1}})) begin
                cnt_d = cnt_q + COUNT_W'(1);
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign hit_cnt[gi*COUNT_W +: COUNT_W] = cnt_q;
    end
`endif

endmodule

// File: tb/tb_decoder_24_pipe.sv
// Directed bench for decoder_24_pipe: stimulus pushes expected words into a queue,
// a negedge monitor pops and compares every delivered word.
module tb_decoder_24_pipe;

`ifdef DECODER_CNT_EN
    localparam int COUNT_W = 2;
    logic                 cnt_clr;
    logic [4*COUNT_W-1:0] hit_cnt;
`endif

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] in_code;
    logic       in_en;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_y;

    int n_vec  = 0;
    int n_miss = 0;
    logic [3:0] exp_q [$];

`ifdef DECODER_CNT_EN
    decoder_24_pipe #(.COUNT_W(COUNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y),
        .cnt_clr   (cnt_clr),
        .hit_cnt   (hit_cnt)
    );
`else
    decoder_24_pipe dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_code   (in_code),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_y     (out_y)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one input beat for one clock; record the hand-computed word if it is accepted.
    task automatic drive(input logic v, input logic [1:0] code, input logic en, input logic [3:0] exp);
        in_valid = v;
        in_code  = code;
        in_en    = en;
        @(negedge clk);
        if (v && in_ready) begin
            exp_q.push_back(exp);
        end
        step();
    endtask

    // Scoreboard monitor: a pop happens at the next posedge whenever valid && ready here.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("FAIL unexpected_word: got %b expected none", out_y);
                end else begin
                    check("delivered_word", {28'd0, out_y}, {28'd0, exp_q.pop_front()});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_code   = 2'd0;
        in_en     = 1'b1;
        out_ready = 1'b0;
`ifdef DECODER_CNT_EN
        cnt_clr   = 1'b0;
`endif
        // Reset held two cycles with in_valid high
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_in_ready", {31'd0, in_ready}, 32'd0);
            check("rst_out_valid", {31'd0, out_valid}, 32'd0);
            check("rst_out_y", {28'd0, out_y}, 32'd0);
        end
`ifdef DECODER_CNT_EN
        check("rst_hit_cnt", {24'd0, hit_cnt}, 32'd0);
`endif
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check("release_in_ready", {31'd0, in_ready}, 32'd1);

        // Decode sweep at full throughput
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 1'b1, 4'b0001);
        check("sweep0_y", {28'd0, out_y}, 32'h1);
        drive(1'b1, 2'd1, 1'b1, 4'b0010);
        check("sweep1_y", {28'd0, out_y}, 32'h2);
        drive(1'b1, 2'd2, 1'b1, 4'b0100);
        check("sweep2_y", {28'd0, out_y}, 32'h4);
        drive(1'b1, 2'd3, 1'b1, 4'b1000);
        check("sweep3_y", {28'd0, out_y}, 32'h8);
        drive(1'b1, 2'd2, 1'b0, 4'b0000);
        check("disabled_valid", {31'd0, out_valid}, 32'd1);
        check("disabled_y", {28'd0, out_y}, 32'h0);
        drive(1'b0, 2'd0, 1'b1, 4'b0000);
        check("sweep_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure fills both entries
        out_ready = 1'b0;
        drive(1'b1, 2'd3, 1'b1, 4'b1000);
        check("bp_first_ready", {31'd0, in_ready}, 32'd1);
        drive(1'b1, 2'd1, 1'b1, 4'b0010);
        check("bp_full_ready", {31'd0, in_ready}, 32'd0);
        check("bp_hold_y", {28'd0, out_y}, 32'h8);
        drive(1'b0, 2'd0, 1'b1, 4'b0000);
        check("bp_hold_y2", {28'd0, out_y}, 32'h8);
        out_ready = 1'b1;
        step();
        check("bp_second_y", {28'd0, out_y}, 32'h2);
        check("bp_ready_back", {31'd0, in_ready}, 32'd1);
        step();
        check("bp_drained", {31'd0, out_valid}, 32'd0);

        // Simultaneous push and pop at occupancy 1
        out_ready = 1'b0;
        drive(1'b1, 2'd2, 1'b1, 4'b0100);
        out_ready = 1'b1;
        drive(1'b1, 2'd0, 1'b1, 4'b0001);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        #1;
        check("pp_y", {28'd0, out_y}, 32'h1);
        check("pp_ready_occ1", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        step();
        check("pp_occ_was_1", {31'd0, out_valid}, 32'd0);

        // Reset mid-stream with both entries occupied
        out_ready = 1'b0;
        drive(1'b1, 2'd0, 1'b1, 4'b0001);
        drive(1'b1, 2'd2, 1'b1, 4'b0100);
        check("mid_full", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        rst      = 1'b1;
        exp_q.delete();
        step();
        check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_y", {28'd0, out_y}, 32'h0);
        rst = 1'b0;
        #1;
        check("mid_release_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 2'd3, 1'b1, 4'b1000);
        check("mid_new_y", {28'd0, out_y}, 32'h8);
        drive(1'b0, 2'd0, 1'b1, 4'b0000);
        check("mid_drained", {31'd0, out_valid}, 32'd0);

`ifdef DECODER_CNT_EN
        // Hit counters, COUNT_W = 2
        cnt_clr = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_cleared", {24'd0, hit_cnt}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 2'd1, 1'b1, 4'b0010);
        end
        drive(1'b1, 2'd0, 1'b0, 4'b0000);
        drive(1'b0, 2'd0, 1'b1, 4'b0000);
        check("cnt_saturated", {24'd0, hit_cnt}, 32'h0C);
        drive(1'b1, 2'd1, 1'b1, 4'b0010);
        in_valid = 1'b0;
        cnt_clr  = 1'b1;
        step();
        cnt_clr = 1'b0;
        check("cnt_clr_wins", {24'd0, hit_cnt}, 32'd0);
        drive(1'b1, 2'd2, 1'b1, 4'b0100);
        drive(1'b0, 2'd0, 1'b1, 4'b0000);
        check("cnt_after_clr", {24'd0, hit_cnt}, 32'h10);
`endif

        step();
        step();
        if (exp_q.size() != 0) begin
            n_vec++;
            n_miss++;
            $display("FAIL undelivered_words: got %0d pending expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
